// File: rtl/dma_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_arb_pkg
//  Description : Shared constants, FSM state type and line-address helper
//                for the DMA cache-line arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_arb_pkg;

    localparam int CL_BYTES   = 64;                 // bytes per cache line
    localparam int LINE_SHIFT = $clog2(CL_BYTES);   // 6: line index -> byte address
    localparam int MAX_ADDR_W = 64;                 // widest address the helper handles

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_GO   = 3'd1,
        RD_WAIT = 3'd2,
        WR_GO   = 3'd3,
        WR_DATA = 3'd4,
        WR_DONE = 3'd5,
        RESP    = 3'd6
    } state_t;

    // Byte address of a cache line; the sum wraps silently on carry-out.
    function automatic logic [MAX_ADDR_W-1:0] line_addr(
        input logic [MAX_ADDR_W-1:0] base,
        input logic [MAX_ADDR_W-1:0] offset
    );
        return base + (offset << LINE_SHIFT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin one-hot arbiter. Priority starts at the pointer
//                and the pointer moves past the winner on each advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             advance,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_cand;
    logic             w_found;

    // Scan requesters starting at the pointer; first active one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_cand    = '0;
        w_found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = PTR_W'((32'(r_ptr) + 32'(k)) % 32'(NREQ));
            if (!w_found && req[w_cand]) begin
                w_found   = 1'b1;
                grant_idx = w_cand;
            end
        end
        if (w_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer moves to winner+1 (mod NREQ) when the grant is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= (32'(grant_idx) == 32'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_line_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dma_line_arbiter
//  Description : Shares one DMA read/write channel pair between NREQ
//                cache-line requesters, one 64-byte line per grant,
//                round-robin, one transfer in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_line_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int LINE_W = 512,
    parameter int OFF_W  = 36,
    parameter int ADDR_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*OFF_W-1:0]  req_offset,
    input  logic [NREQ*LINE_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        resp_valid,
    output logic [LINE_W-1:0]      resp_rdata,
    output logic                   busy,
    output logic [ADDR_W-1:0]      dma_rd_addr,
    output logic [ADDR_W-1:0]      dma_wr_addr,
    output logic                   dma_rd_go,
    output logic                   dma_wr_go,
    output logic                   dma_rd_en,
    output logic                   dma_wr_en,
    input  logic [LINE_W-1:0]      dma_rd_data,
    output logic [LINE_W-1:0]      dma_wr_data,
    input  logic                   dma_empty,
    input  logic                   dma_full,
    input  logic                   dma_rd_done,
    input  logic                   dma_wr_done
);

    localparam int PTR_W = $clog2(NREQ);

    state_t                r_state;
    state_t                w_next;
    logic [PTR_W-1:0]      r_sel;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [LINE_W-1:0]     r_wdata;
    logic [LINE_W-1:0]     r_rdata;

    logic [NREQ-1:0]       w_grant;
    logic [PTR_W-1:0]      w_grant_idx;
    logic                  w_idle_grant;
    logic [OFF_W-1:0]      w_off;
    logic [MAX_ADDR_W-1:0] w_line;
    logic                  w_rd_go, w_wr_go, w_rd_en, w_wr_en, w_resp, w_busy;
    logic                  w_unused;

    // Read completion is implied by the data pop, so rd_done carries no information here.
    assign w_unused = dma_rd_done;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (w_idle_grant),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_idle_grant = (r_state == IDLE) && (|req_valid) && !rst;
    assign w_off        = req_offset[32'(w_grant_idx)*OFF_W +: OFF_W];
    assign w_line       = line_addr(MAX_ADDR_W'(base_addr), MAX_ADDR_W'(w_off));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and single-cycle strobes; everything is quiet while rst is high.
    always_comb begin
        w_next  = r_state;
        w_rd_go = 1'b0;
        w_wr_go = 1'b0;
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        w_resp  = 1'b0;
        w_busy  = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    w_busy = w_idle_grant;
                    if (w_idle_grant) begin
                        w_next = req_we[w_grant_idx] ? WR_GO : RD_GO;
                    end
                end
                RD_GO: begin
                    w_busy  = 1'b1;
                    w_rd_go = 1'b1;
                    w_next  = RD_WAIT;
                end
                RD_WAIT: begin
                    w_busy = 1'b1;
                    if (!dma_empty) begin
                        w_rd_en = 1'b1;
                        w_next  = RESP;
                    end
                end
                WR_GO: begin
                    w_busy  = 1'b1;
                    w_wr_go = 1'b1;
                    w_next  = WR_DATA;
                end
                WR_DATA: begin
                    w_busy = 1'b1;
                    if (!dma_full) begin
                        w_wr_en = 1'b1;
                        w_next  = WR_DONE;
                    end
                end
                WR_DONE: begin
                    w_busy = 1'b1;
                    if (dma_wr_done) begin
                        w_next = RESP;
                    end
                end
                RESP: begin
                    w_busy = 1'b1;
                    w_resp = 1'b1;
                    w_next = IDLE;
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    // Latch the winner's request at grant and capture read data on the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_idle_grant) begin
                r_sel   <= w_grant_idx;
                r_we    <= req_we[w_grant_idx];
                r_addr  <= ADDR_W'(w_line);
                r_wdata <= req_wdata[32'(w_grant_idx)*LINE_W +: LINE_W];
            end
            if (w_rd_en) begin
                r_rdata <= dma_rd_data;
            end
        end
    end

    assign req_ready   = w_idle_grant ? w_grant : '0;
    assign resp_valid  = w_resp ? (NREQ'(1) << r_sel) : '0;
    assign resp_rdata  = r_rdata;
    assign busy        = w_busy;
    assign dma_rd_addr = r_we ? '0 : r_addr;
    assign dma_wr_addr = r_we ? r_addr : '0;
    assign dma_wr_data = r_wdata;
    assign dma_rd_go   = w_rd_go;
    assign dma_wr_go   = w_wr_go;
    assign dma_rd_en   = w_rd_en;
    assign dma_wr_en   = w_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_dma_line_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_line_arbiter
//  Description : Directed bench for dma_line_arbiter: a vector table of
//                single transfers plus hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_line_arbiter;

    localparam int NREQ   = 2;
    localparam int LINE_W = 512;
    localparam int OFF_W  = 36;
    localparam int ADDR_W = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [ADDR_W-1:0]      base_addr;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*OFF_W-1:0]  req_offset;
    logic [NREQ*LINE_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        resp_valid;
    logic [LINE_W-1:0]      resp_rdata;
    logic                   busy;
    logic [ADDR_W-1:0]      dma_rd_addr, dma_wr_addr;
    logic                   dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en;
    logic [LINE_W-1:0]      dma_rd_data;
    logic [LINE_W-1:0]      dma_wr_data;
    logic                   dma_empty, dma_full, dma_rd_done, dma_wr_done;

    dma_line_arbiter #(
        .NREQ(NREQ), .LINE_W(LINE_W), .OFF_W(OFF_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .base_addr(base_addr),
        .req_valid(req_valid), .req_we(req_we), .req_offset(req_offset),
        .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .busy(busy),
        .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
        .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go),
        .dma_rd_en(dma_rd_en), .dma_wr_en(dma_wr_en),
        .dma_rd_data(dma_rd_data), .dma_wr_data(dma_wr_data),
        .dma_empty(dma_empty), .dma_full(dma_full),
        .dma_rd_done(dma_rd_done), .dma_wr_done(dma_wr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                who;
        logic              we;
        logic [OFF_W-1:0]  off;
        logic [7:0]        pat;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    vec_t vecs[5];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int who, input logic we, input logic [OFF_W-1:0] off, input logic [7:0] pat);
        req_valid[who]                  = 1'b1;
        req_we[who]                     = we;
        req_offset[who*OFF_W +: OFF_W]  = off;
        req_wdata[who*LINE_W +: LINE_W] = {64{pat}};
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " req_ready"}, req_ready, '0);
        check({tag, " resp_valid"}, resp_valid, '0);
        check({tag, " busy"}, busy, '0);
        check({tag, " strobes"}, {dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}, '0);
        check({tag, " resp_rdata"}, resp_rdata, '0);
        check({tag, " rd_addr"}, dma_rd_addr, '0);
        check({tag, " wr_addr"}, dma_wr_addr, '0);
        check({tag, " wr_data"}, dma_wr_data, '0);
    endtask

    // One uncontended transfer with a DMA that never stalls.
    task automatic run_txn(input vec_t v, input string tag);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[v.who] = 1'b1;
        tick();
        base_addr   = v.base;
        dma_empty   = 1'b0;
        dma_full    = 1'b0;
        dma_rd_data = {64{v.pat}};
        req_valid   = '0;
        set_req(v.who, v.we, v.off, v.pat);
        #1;
        check({tag, " grant"}, req_ready, oh);
        check({tag, " busy@grant"}, busy, 1'b1);
        tick();
        req_valid = '0;
        #1;
        if (!v.we) begin
            check({tag, " rd_go"}, {dma_rd_go, dma_wr_go}, 2'b10);
            check({tag, " rd_addr"}, dma_rd_addr, v.exp_addr);
        end else begin
            check({tag, " wr_go"}, {dma_rd_go, dma_wr_go}, 2'b01);
            check({tag, " wr_addr"}, dma_wr_addr, v.exp_addr);
        end
        tick();
        #1;
        if (!v.we) begin
            check({tag, " rd_en"}, {dma_rd_en, dma_wr_en}, 2'b10);
        end else begin
            check({tag, " wr_en"}, {dma_rd_en, dma_wr_en}, 2'b01);
            check({tag, " wr_data"}, dma_wr_data, {64{v.pat}});
            tick();
            dma_wr_done = 1'b1;
            #1;
            check({tag, " no early resp"}, resp_valid, '0);
        end
        tick();
        dma_wr_done = 1'b0;
        #1;
        check({tag, " resp_valid"}, resp_valid, oh);
        if (!v.we) begin
            check({tag, " resp_rdata"}, resp_rdata, {64{v.pat}});
        end
        tick();
        #1;
        check({tag, " idle busy"}, busy, 1'b0);
        check({tag, " idle resp"}, resp_valid, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int ng;
        int nr;
        logic [NREQ-1:0] last_oh;
        logic [NREQ-1:0] exp_oh;

        vecs[0] = '{64'h0000_0000_0000_1000, 0, 1'b0, 36'd3,           8'hAB, 64'h0000_0000_0000_10C0};
        vecs[1] = '{64'h0000_0000_0000_1000, 1, 1'b1, 36'd0,           8'h55, 64'h0000_0000_0000_1000};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFC0, 0, 1'b0, 36'd2,           8'h3C, 64'h0000_0000_0000_0040};
        vecs[3] = '{64'h0000_0000_2000_0000, 1, 1'b0, 36'hF_FFFF_FFFF, 8'h99, 64'h0000_0400_1FFF_FFC0};
        vecs[4] = '{64'h0000_0000_0000_0000, 0, 1'b1, 36'h123,         8'hC3, 64'h0000_0000_0000_48C0};

        rst         = 1'b1;
        base_addr   = '0;
        req_valid   = '0;
        req_we      = '0;
        req_offset  = '0;
        req_wdata   = '0;
        dma_rd_data = '0;
        dma_empty   = 1'b1;
        dma_full    = 1'b1;
        dma_rd_done = 1'b0;
        dma_wr_done = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        check_quiet("reset");
        rst = 1'b0;
        tick();
        #1;
        check_quiet("post-reset");

        // Table of single transfers
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Write with the DMA FIFO full for four cycles
        tick();
        base_addr = 64'h1000;
        req_valid = '0;
        set_req(1, 1'b1, 36'd0, 8'h55);
        #1;
        check("wrfull grant", req_ready, 2'b10);
        tick();
        req_valid = '0;
        dma_full  = 1'b1;
        #1;
        check("wrfull wr_go", dma_wr_go, 1'b1);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            if (dma_wr_en || !busy) bad++;
        end
        check("wrfull no wr_en while full", bad, 0);
        tick();
        dma_full = 1'b0;
        #1;
        check("wrfull wr_en", dma_wr_en, 1'b1);
        check("wrfull wr_data", dma_wr_data, {64{8'h55}});
        check("wrfull wr_addr", dma_wr_addr, 64'h1000);
        bad = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            if (resp_valid != '0 || !busy) bad++;
        end
        check("wrfull wait wr_done", bad, 0);
        dma_wr_done = 1'b1;
        tick();
        dma_wr_done = 1'b0;
        #1;
        check("wrfull resp", resp_valid, 2'b10);

        // Contention: both requesters read continuously for four grants
        tick();
        base_addr   = 64'h1000;
        dma_empty   = 1'b0;
        dma_rd_data = {64{8'h5A}};
        req_valid   = '0;
        set_req(0, 1'b0, 36'd1, 8'h11);
        set_req(1, 1'b0, 36'd2, 8'h22);
        ng = 0;
        nr = 0;
        last_oh = '0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) tick();
            if (ng == 4) req_valid = '0;
            #1;
            if (req_ready != '0) begin
                exp_oh = (ng % 2 == 0) ? 2'b01 : 2'b10;
                check($sformatf("cont grant%0d", ng), req_ready, exp_oh);
                last_oh = req_ready;
                ng++;
            end
            if (resp_valid != '0) begin
                check($sformatf("cont resp%0d", nr), resp_valid, last_oh);
                nr++;
            end
        end
        check("cont grant count", ng, 4);
        check("cont resp count", nr, 4);

        // Stall: FIFO empty for twenty cycles in RD_WAIT
        tick();
        base_addr   = 64'h1000;
        dma_empty   = 1'b1;
        dma_rd_data = {64{8'hE7}};
        req_valid   = '0;
        set_req(0, 1'b0, 36'd5, 8'h00);
        #1;
        check("stall grant", req_ready, 2'b01);
        tick();
        req_valid = '0;
        #1;
        check("stall rd_addr", dma_rd_addr, 64'h1140);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            #1;
            if (dma_rd_en || !busy || resp_valid != '0) bad++;
        end
        check("stall no rd_en while empty", bad, 0);
        tick();
        dma_empty = 1'b0;
        #1;
        check("stall rd_en", dma_rd_en, 1'b1);
        tick();
        #1;
        check("stall resp", resp_valid, 2'b01);
        check("stall rdata", resp_rdata, {64{8'hE7}});

        // Reset while waiting in RD_WAIT
        tick();
        dma_empty = 1'b1;
        set_req(0, 1'b0, 36'd7, 8'h00);
        #1;
        check("rstmid grant", req_ready, 2'b01);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        dma_empty = 1'b0;
        #1;
        check_quiet("rstmid");
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            if (resp_valid != '0 || busy || dma_rd_en) bad++;
        end
        check("rstmid no resp", bad, 0);
        run_txn(vecs[3], "rstmid fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_line_arbiter.md
# dma_line_arbiter

Shares the AFU's single DMA read/write channel pair between NREQ cache-line requesters, such as I-cache fill and D-cache fill/writeback, in the cache test hierarchy. Each granted request moves exactly one 64-byte cache line. The address is `base_addr + offset*64`, with `base_addr` taken from the memory map. Arbitration is round-robin, and only one transfer is in flight at a time.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- LINE_W, 512, cache line width in bits
- OFF_W, 36, cache-line offset width
- ADDR_W, 64, virtual byte address width

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- base_addr  in  ADDR_W  virtual byte base of the line buffer
- req_valid  in  NREQ  per-requester request; held until its req_ready
- req_we  in  NREQ  1 = write line to host, 0 = read line from host
- req_offset  in  NREQ*OFF_W  line index, packed with requester i at [i*OFF_W +: OFF_W]
- req_wdata  in  NREQ*LINE_W  write data, packed the same way
- req_ready  out  NREQ  one-cycle, one-hot grant pulse
- resp_valid  out  NREQ  one-cycle, one-hot completion pulse to the granted requester
- resp_rdata  out  LINE_W  read line; valid when resp_valid is high and the request was a read
- busy  out  1  high from grant through the response cycle
- dma_rd_addr, dma_wr_addr  out  ADDR_W  transfer address
- dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en  out  1  DMA strobes (single-cycle)
- dma_rd_data  in  LINE_W;  dma_wr_data  out  LINE_W
- dma_empty, dma_full, dma_rd_done, dma_wr_done  in  1  DMA status

## Operation
- The DMA size ports are tied to 1 outside this block.
- States: IDLE, RD_GO, RD_WAIT, WR_GO, WR_DATA, WR_DONE, RESP.
- IDLE:
  - If any req_valid is high, the round-robin winner i gets req_ready[i]=1.
  - The block latches i, req_we[i], req_offset[i] and req_wdata[i].
  - The FSM moves to RD_GO or WR_GO.
  - The RR pointer moves to i+1 mod NREQ.
- Address: `{offset, 6'b0}` is zero-extended to ADDR_W and added to base_addr modulo 2^ADDR_W, so a carry-out wraps silently. The result is registered at grant and held on the rd or wr address port until RESP.
- RD_GO: pulse dma_rd_go for one cycle, then go to RD_WAIT.
- RD_WAIT: when dma_empty=0, pulse dma_rd_en for one cycle and capture dma_rd_data into resp_rdata in the same cycle. Then go to RESP. dma_rd_done is ignored.
- WR_GO: pulse dma_wr_go, then go to WR_DATA.
- WR_DATA: drive the latched data on dma_wr_data. When dma_full=0, pulse dma_wr_en and go to WR_DONE.
- WR_DONE: wait for dma_wr_done=1, then go to RESP.
- RESP: pulse resp_valid[i] for one cycle, then return to IDLE.
- resp_rdata holds its value until the next read capture.
- Non-granted requesters keep req_valid high. They are not dropped.

## Timing
- Reset values:
  - All strobes, req_ready, resp_valid and busy are 0.
  - resp_rdata, the address ports and dma_wr_data are 0.
  - State is IDLE and the RR pointer is 0.
- Read, best case:
  - grant at T
  - dma_rd_go at T+1
  - dma_rd_en at T+2 if dma_empty=0
  - resp_valid at T+3
  - next grant no earlier than T+4
- Write, best case:
  - grant at T
  - dma_wr_go at T+1
  - dma_wr_en at T+2 if dma_full=0
  - resp_valid one cycle after dma_wr_done is sampled high in WR_DONE
- A requester must deassert req_valid, or change its request, in the cycle after req_ready. Holding it asserts a new request.
- dma_rd_en is never high while dma_empty=1. dma_wr_en is never high while dma_full=1.
- dma_empty or dma_full stuck high causes an indefinite wait with busy=1. There is no timeout.
- rst in any state returns to IDLE next cycle with all outputs at reset values. The in-flight transfer is abandoned and no resp_valid is issued.
- req_valid changes during busy do not affect the current transfer.

## Structure
- Package dma_arb_pkg holds:
  - CL_BYTES=64 and the line-shift constant 6
  - the state enum type
  - a line_addr(base, offset) function
- Sub-module rr_arbiter (parameter NREQ) provides the one-hot grant and pointer update. It takes req, an advance strobe, and outputs grant.

## Test plan
- Single read: base_addr=0x1000, req 0 with offset=3, DMA returns 0xAB.. -> dma_rd_addr=0x10C0, resp_valid[0] at T+3, resp_rdata=0xAB...
- Single write: req 1 with offset=0, data 0x55.., dma_full high for 4 cycles -> dma_wr_en only after full drops, dma_wr_data=0x55.., resp_valid[1] one cycle after wr_done.
- Contention: both requesters hold valid for 4 transactions -> grants alternate 0,1,0,1 and exactly one resp per grant.
- Wrap: base_addr=0xFFFF_FFFF_FFFF_FFC0, offset=2 -> address 0x40.
- Stall: dma_empty held high for 20 cycles -> no rd_en, busy=1, completes normally afterward.
- Reset mid-read (in RD_WAIT) -> next cycle IDLE, all outputs 0, no resp_valid, a fresh request works.
